stack_controller: RTL and testbench
===================================

STACK_CONTROLLER -- requirements
Module: stack_controller

Interface
REQ-001 Parameter BLOCK_W, default 16, block width in pixels; overlap tolerance for a successful drop.
REQ-002 Parameter X_MAX, default 144, rightmost legal block x position.
REQ-003 Parameter ROWS, default 7, number of rows needed to win.
REQ-004 clk  in  1  single system clock; all state SHALL change on its rising edge.
REQ-005 resetn  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  level/pulse; begins a new game from IDLE, OVER or WIN.
REQ-007 drop  in  1  one-cycle player drop pulse.
REQ-008 frame_tick  in  1  one-cycle pulse per video frame.
REQ-009 new_x_position  in  8  start x of the current row, from the row counter.
REQ-010 new_y_position  in  7  y of the current row, from the row counter.
REQ-011 new_direction  in  1  start direction: 1 = right, 0 = left.
REQ-012 difficulty  in  3  frames per one-pixel step; 0 SHALL be treated as 1.
REQ-013 draw_ack  in  1  drawer has accepted the current x_pos/y_pos.
REQ-014 inc_row  out  1  one-cycle pulse that advances the row counter.
REQ-015 row_clr_n  out  1  active-low one-cycle clear that drives the row counter's reset.
REQ-016 x_pos  out  8  current block x position.
REQ-017 y_pos  out  7  current block y position.
REQ-018 draw_req  out  1  request to redraw the block at x_pos/y_pos.
REQ-019 score  out  3  rows placed successfully.
REQ-020 game_over  out  1  high while in OVER.
REQ-021 game_win  out  1  high while in WIN.

Function
REQ-022 FSM states SHALL be IDLE, CLEAR, LOAD, DRAW, MOVE, CHECK, NEXT, OVER and WIN.
REQ-023 IDLE/OVER/WIN: start=1 -> CLEAR; otherwise hold.
REQ-024 CLEAR: row_clr_n=0 for exactly this cycle; clear score, prev_x, frame counter and drop_pend; -> LOAD.
REQ-025 LOAD: latch x_pos<=new_x_position, y_pos<=new_y_position, dir<=new_direction; clear frame counter; -> DRAW.
REQ-026 DRAW: draw_req=1, with x_pos/y_pos held stable; transfer occurs on a cycle where draw_req&draw_ack=1; then -> MOVE, and draw_req drops the next cycle.
REQ-027 MOVE: if drop or drop_pend -> CHECK, clearing drop_pend; this has priority over frame_tick in the same cycle.
REQ-028 MOVE on frame_tick: frame counter increments; when counter+1 >= max(difficulty,1), the block steps one pixel, the counter clears, and the FSM goes -> DRAW.
REQ-029 Step rule, moving right: x==X_MAX -> dir<=0, x<=X_MAX-1; else x+1.
REQ-030 Step rule, moving left: x==0 -> dir<=1, x<=1; else x-1.
REQ-031 drop arriving in LOAD or DRAW SHALL set drop_pend; drop in other states SHALL be ignored.
REQ-032 frame_tick outside MOVE SHALL be ignored.
REQ-033 CHECK success: score==0, or |x_pos-prev_x| < BLOCK_W, using 9-bit unsigned difference with no wrap.
REQ-034 CHECK on success: prev_x<=x_pos, score<=score+1, -> NEXT.
REQ-035 CHECK on failure: -> OVER; score is unchanged.
REQ-036 NEXT: inc_row=1 for this cycle only; if score==ROWS -> WIN, else -> LOAD, which samples the row counter outputs already advanced.
REQ-037 inc_row, row_clr_n pulses and draw_req SHALL be registered outputs with no combinational path from inputs.

Reset
REQ-038 resetn=0 SHALL force asynchronously: state IDLE, x_pos=0, y_pos=0, dir=0, score=0, prev_x=0, frame counter=0, drop_pend=0, inc_row=0, draw_req=0, row_clr_n=1, game_over=0, game_win=0.
REQ-039 Reset mid-operation, including during an open draw handshake, SHALL abandon it with no pulse emitted on release.
REQ-040 The row counter SHALL be cleared only through row_clr_n, via CLEAR after start.

Verification
REQ-041 Reset, then start; row inputs (0,104,1,diff 3): row_clr_n low one cycle, then x_pos=0 and y_pos=104 with draw_req=1; with ack, x reaches 1 after 3 frame_ticks.
REQ-042 Right edge: x=144, dir=1, one step -> x=143, dir=0; left edge: x=0, dir=0 -> x=1, dir=1.
REQ-043 Drop row 0 at x=50 -> inc_row one pulse, score=1; row 1 dropped at x=65 -> success, score=2; dropped at x=66 instead -> game_over=1, no inc_row.
REQ-044 drop and frame_tick in the same MOVE cycle -> CHECK, x unchanged; drop during DRAW with ack delayed 5 cycles -> CHECK the cycle after MOVE is entered.
REQ-045 Seven successful drops -> score=7, game_win=1, seven inc_row pulses total; start then -> CLEAR and score=0.
REQ-046 difficulty=0 -> one step per frame_tick; resetn low during DRAW -> draw_req=0 immediately, state IDLE.

Source files
------------

// File: rtl/stack_controller.sv
// Stacker game controller: sweeps a block across the current row, checks each drop
// against the previous row, and tracks score, game-over and win.
module stack_controller #(
    parameter int unsigned BLOCK_W = 16,
    parameter int unsigned X_MAX   = 144,
    parameter int unsigned ROWS    = 7
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic       drop,
    input  logic       frame_tick,
    input  logic [7:0] new_x_position,
    input  logic [6:0] new_y_position,
    input  logic       new_direction,
    input  logic [2:0] difficulty,
    input  logic       draw_ack,
    output logic       inc_row,
    output logic       row_clr_n,
    output logic [7:0] x_pos,
    output logic [6:0] y_pos,
    output logic       draw_req,
    output logic [2:0] score,
    output logic       game_over,
    output logic       game_win
);

    typedef enum logic [3:0] {
        StIdle,
        StClear,
        StLoad,
        StDraw,
        StMove,
        StCheck,
        StNext,
        StOver,
        StWin
    } state_e;

    localparam logic [7:0] XMaxL   = 8'(X_MAX);
    localparam logic [8:0] BlockWL = 9'(BLOCK_W);
    localparam logic [2:0] RowsL   = 3'(ROWS);

    state_e     state_q, state_d;
    logic [7:0] x_q, x_d;
    logic [6:0] y_q, y_d;
    logic       dir_q, dir_d;
    logic [2:0] score_q, score_d;
    logic [7:0] prev_x_q, prev_x_d;
    logic [2:0] frame_cnt_q, frame_cnt_d;
    logic       drop_pend_q, drop_pend_d;
    logic       inc_row_q, row_clr_n_q, draw_req_q, game_over_q, game_win_q;

    // One-pixel step with bounce at either edge.
    logic [7:0] x_step;
    logic       dir_step;

    always_comb begin
        x_step   = x_q;
        dir_step = dir_q;
        if (dir_q) begin
            if (x_q == XMaxL) begin
                x_step   = XMaxL - 8'd1;
                dir_step = 1'b0;
            end else begin
                x_step = x_q + 8'd1;
            end
        end else begin
            if (x_q == 8'd0) begin
                x_step   = 8'd1;
                dir_step = 1'b1;
            end else begin
                x_step = x_q - 8'd1;
            end
        end
    end

    // A difficulty of 0 behaves as 1 frame per step.
    logic [2:0] diff_eff;
    logic [3:0] cnt_inc;
    logic       step_due;

    always_comb begin
        diff_eff = (difficulty == 3'd0) ? 3'd1 : difficulty;
        cnt_inc  = {1'b0, frame_cnt_q} + 4'd1;
        step_due = cnt_inc >= {1'b0, diff_eff};
    end

    // Overlap test uses a widened magnitude so the difference never wraps.
    logic [8:0] x_diff;
    logic       drop_ok;

    always_comb begin
        if (x_q >= prev_x_q) begin
            x_diff = {1'b0, x_q} - {1'b0, prev_x_q};
        end else begin
            x_diff = {1'b0, prev_x_q} - {1'b0, x_q};
        end
        drop_ok = (score_q == 3'd0) || (x_diff < BlockWL);
    end

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        dir_d       = dir_q;
        score_d     = score_q;
        prev_x_d    = prev_x_q;
        frame_cnt_d = frame_cnt_q;
        drop_pend_d = drop_pend_q;

        unique case (state_q)
            StIdle, StOver, StWin: begin
                if (start) begin
                    state_d = StClear;
                end
            end
            StClear: begin
                score_d     = 3'd0;
                prev_x_d    = 8'd0;
                frame_cnt_d = 3'd0;
                drop_pend_d = 1'b0;
                state_d     = StLoad;
            end
            StLoad: begin
                x_d         = new_x_position;
                y_d         = new_y_position;
                dir_d       = new_direction;
                frame_cnt_d = 3'd0;
                if (drop) begin
                    drop_pend_d = 1'b1;
                end
                state_d = StDraw;
            end
            StDraw: begin
                if (drop) begin
                    drop_pend_d = 1'b1;
                end
                if (draw_req_q && draw_ack) begin
                    state_d = StMove;
                end
            end
            StMove: begin
                // A drop wins over a coincident frame tick.
                if (drop || drop_pend_q) begin
                    drop_pend_d = 1'b0;
                    state_d     = StCheck;
                end else if (frame_tick) begin
                    if (step_due) begin
                        x_d         = x_step;
                        dir_d       = dir_step;
                        frame_cnt_d = 3'd0;
                        state_d     = StDraw;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 3'd1;
                    end
                end
            end
            StCheck: begin
                if (drop_ok) begin
                    prev_x_d = x_q;
                    score_d  = score_q + 3'd1;
                    state_d  = StNext;
                end else begin
                    state_d = StOver;
                end
            end
            StNext: begin
                state_d = (score_q == RowsL) ? StWin : StLoad;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= StIdle;
            x_q         <= 8'd0;
            y_q         <= 7'd0;
            dir_q       <= 1'b0;
            score_q     <= 3'd0;
            prev_x_q    <= 8'd0;
            frame_cnt_q <= 3'd0;
            drop_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            dir_q       <= dir_d;
            score_q     <= score_d;
            prev_x_q    <= prev_x_d;
            frame_cnt_q <= frame_cnt_d;
            drop_pend_q <= drop_pend_d;
        end
    end

    // Outputs are registered from the next state so each is high exactly while in its state.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            inc_row_q   <= 1'b0;
            row_clr_n_q <= 1'b1;
            draw_req_q  <= 1'b0;
            game_over_q <= 1'b0;
            game_win_q  <= 1'b0;
        end else begin
            inc_row_q   <= (state_d == StNext);
            row_clr_n_q <= (state_d != StClear);
            draw_req_q  <= (state_d == StDraw);
            game_over_q <= (state_d == StOver);
            game_win_q  <= (state_d == StWin);
        end
    end

    assign inc_row   = inc_row_q;
    assign row_clr_n = row_clr_n_q;
    assign draw_req  = draw_req_q;
    assign game_over = game_over_q;
    assign game_win  = game_win_q;
    assign x_pos     = x_q;
    assign y_pos     = y_q;
    assign score     = score_q;

endmodule

// File: tb/tb_stack_controller.sv
// Bench for stack_controller: directed game scenarios plus randomized games checked
// against a position model based on an unfolded bounce phase.
module tb_stack_controller;

    localparam int XM = 144;
    localparam int BW = 16;
    localparam int NR = 7;

    logic       clk = 1'b0;
    logic       resetn;
    logic       start, drop, frame_tick, new_direction, draw_ack;
    logic [7:0] new_x_position;
    logic [6:0] new_y_position;
    logic [2:0] difficulty;
    logic       inc_row, row_clr_n, draw_req, game_over, game_win;
    logic [7:0] x_pos;
    logic [6:0] y_pos;
    logic [2:0] score;

    always #5 clk = ~clk;

    stack_controller dut (
        .clk           (clk),
        .resetn        (resetn),
        .start         (start),
        .drop          (drop),
        .frame_tick    (frame_tick),
        .new_x_position(new_x_position),
        .new_y_position(new_y_position),
        .new_direction (new_direction),
        .difficulty    (difficulty),
        .draw_ack      (draw_ack),
        .inc_row       (inc_row),
        .row_clr_n     (row_clr_n),
        .x_pos         (x_pos),
        .y_pos         (y_pos),
        .draw_req      (draw_req),
        .score         (score),
        .game_over     (game_over),
        .game_win      (game_win)
    );

    int checks   = 0;
    int failures = 0;
    int inc_cnt  = 0;
    int clr_cnt  = 0;

    always @(posedge clk) begin
        if (inc_row === 1'b1) inc_cnt++;
        if (row_clr_n === 1'b0) clr_cnt++;
    end

    // Model: block position is a triangle wave of an unfolded phase m_u (period 2*XM).
    int m_u, m_ticks, m_dd, m_score, m_prev, game_inc_base;

    function automatic int pos_of(input int u);
        int w;
        w = u % (2 * XM);
        return (w <= XM) ? w : 2 * XM - w;
    endfunction

    function automatic int unfold(input int x, input int dir);
        return dir != 0 ? x : (2 * XM - x) % (2 * XM);
    endfunction

    function automatic int iabs(input int v);
        return v < 0 ? -v : v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic start_game(input int x, input int y, input int dir, input int diff);
        int c0;
        c0 = clr_cnt;
        new_x_position = 8'(x);
        new_y_position = 7'(y);
        new_direction  = dir[0];
        difficulty     = 3'(diff);
        start          = 1'b1;
        step();
        start = 1'b0;
        chk("clr_low", row_clr_n, 0);
        step();
        chk("clr_high", row_clr_n, 1);
        chk("clr_score", score, 0);
        chk("clr_over", game_over, 0);
        step();
        chk("load_req", draw_req, 1);
        chk("load_x", x_pos, x);
        chk("load_y", y_pos, y);
        chk("clr_once", clr_cnt - c0, 1);
        m_u           = unfold(x, dir);
        m_ticks       = 0;
        m_dd          = (diff == 0) ? 1 : diff;
        m_score       = 0;
        m_prev        = 0;
        game_inc_base = inc_cnt;
    endtask

    task automatic ack();
        draw_ack = 1'b1;
        step();
        draw_ack = 1'b0;
        chk("ack_req_low", draw_req, 0);
    endtask

    task automatic tick(output bit stepped);
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        m_ticks++;
        stepped = (m_ticks % m_dd) == 0;
        if (stepped) m_u++;
        chk("tick_req", draw_req, stepped);
        chk("tick_x", x_pos, pos_of(m_u));
    endtask

    task automatic move_row(input int n);
        bit s;
        for (int i = 0; i < n; i++) begin
            tick(s);
            if (s) ack();
        end
    endtask

    task automatic ignored_tick();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        chk("draw_tick_req", draw_req, 1);
        chk("draw_tick_x", x_pos, pos_of(m_u));
    endtask

    // Drop while the block is still being drawn, with the ack held off for a while.
    task automatic pend_drop(input int delay);
        drop = 1'b1;
        step();
        drop = 1'b0;
        repeat (delay) step();
        chk("pend_req", draw_req, 1);
        ack();
    endtask

    // Entered in MOVE; res: 0 = next row loaded, 1 = over, 2 = win.
    task automatic finish_row(input bit pend, input bit with_tick, input int nx, input int ny,
                              input int ndir, input int ndiff, output int res);
        int  x_now;
        bit  succ, win;
        new_x_position = 8'(nx);
        new_y_position = 7'(ny);
        new_direction  = ndir[0];
        difficulty     = 3'(ndiff);
        if (!pend) drop = 1'b1;
        if (with_tick) frame_tick = 1'b1;
        step();
        drop       = 1'b0;
        frame_tick = 1'b0;
        x_now = pos_of(m_u);
        succ  = (m_score == 0) || (iabs(x_now - m_prev) < BW);
        if (succ) begin
            m_score++;
            m_prev = x_now;
        end
        step();
        chk("res_inc", inc_row, succ);
        chk("res_over", game_over, !succ);
        chk("res_score", score, m_score);
        chk("res_x", x_pos, x_now);
        step();
        win = succ && (m_score == NR);
        chk("res_inc_off", inc_row, 0);
        chk("res_win", game_win, win);
        res = !succ ? 1 : (win ? 2 : 0);
        if (res == 0) begin
            step();
            chk("row_req", draw_req, 1);
            chk("row_x", x_pos, nx);
            chk("row_y", y_pos, ny);
            m_u     = unfold(nx, ndir);
            m_ticks = 0;
            m_dd    = (ndiff == 0) ? 1 : ndiff;
        end
    endtask

    int res, nx, cur, inc0;
    bit pend, s;

    initial begin
        resetn = 1'b0;
        {start, drop, frame_tick, new_direction, draw_ack} = '0;
        new_x_position = '0;
        new_y_position = '0;
        difficulty     = '0;
        step();
        step();
        chk("rst_req", draw_req, 0);
        chk("rst_inc", inc_row, 0);
        chk("rst_clr", row_clr_n, 1);
        chk("rst_x", x_pos, 0);
        chk("rst_y", y_pos, 0);
        chk("rst_score", score, 0);
        chk("rst_over", game_over, 0);
        chk("rst_win", game_win, 0);
        resetn = 1'b1;
        repeat (3) step();
        chk("idle_hold_req", draw_req, 0);
        chk("idle_hold_clr", row_clr_n, 1);

        // First row at difficulty 3, then both edge bounces and difficulty 0.
        start_game(0, 104, 1, 3);
        ack();
        move_row(3);
        chk("diff3_x", x_pos, 1);
        finish_row(0, 0, 0, 96, 0, 0, res);
        ack();
        move_row(2);
        chk("left_edge_x", x_pos, 2);
        finish_row(0, 0, 144, 88, 1, 1, res);
        ack();
        move_row(2);
        chk("right_edge_x", x_pos, 142);
        finish_row(0, 0, 0, 0, 0, 1, res);
        chk("edge_game_over", res, 1);

        // Overlap exactly BLOCK_W fails.
        start_game(50, 100, 1, 1);
        ack();
        finish_row(0, 0, 66, 90, 0, 1, res);
        ack();
        inc0 = inc_cnt;
        finish_row(0, 0, 0, 0, 0, 1, res);
        chk("overlap16_over", res, 1);
        chk("overlap16_no_inc", inc_cnt - inc0, 0);

        // Overlap 15 passes; then drop priority, pending drop, and a full win.
        start_game(50, 100, 1, 1);
        ack();
        finish_row(0, 0, 60, 90, 1, 1, res);
        ack();
        move_row(5);
        chk("row1_x", x_pos, 65);
        finish_row(0, 0, 60, 80, 1, 2, res);
        chk("overlap15_ok", res, 0);
        ack();
        move_row(1);
        finish_row(0, 1, 60, 70, 1, 2, res);
        pend_drop(5);
        finish_row(1, 1, 60, 60, 0, 4, res);
        for (int r = 0; r < 3; r++) begin
            ack();
            finish_row(0, 0, 60, 50 - r, 0, 4, res);
        end
        chk("win_res", res, 2);
        chk("win_flag", game_win, 1);
        chk("win_score", score, 7);
        chk("win_inc_pulses", inc_cnt - game_inc_base, 7);
        start_game(10, 20, 1, 1);

        // Reset during an open draw handshake.
        draw_ack = 1'b1;
        resetn   = 1'b0;
        #1;
        chk("rst_draw_req", draw_req, 0);
        chk("rst_draw_x", x_pos, 0);
        inc0 = inc_cnt;
        step();
        resetn = 1'b1;
        repeat (3) step();
        draw_ack = 1'b0;
        chk("rst_rel_req", draw_req, 0);
        chk("rst_rel_clr", row_clr_n, 1);
        chk("rst_rel_inc", inc_cnt - inc0, 0);
        chk("rst_rel_score", score, 0);
        chk("rst_rel_over", game_over, 0);

        // Randomized games.
        for (int g = 0; g < 12; g++) begin
            start_game($urandom_range(0, 144), $urandom_range(0, 127), $urandom_range(0, 1),
                       $urandom_range(0, 7));
            res = 0;
            while (res == 0) begin
                pend = ($urandom_range(0, 3) == 0);
                if (pend) begin
                    pend_drop($urandom_range(0, 5));
                end else begin
                    if ($urandom_range(0, 1) == 1) ignored_tick();
                    ack();
                    move_row($urandom_range(0, 8));
                end
                cur = pos_of(m_u);
                nx  = cur + int'($urandom_range(0, 24)) - 12;
                if (nx < 0) nx = 0;
                if (nx > XM) nx = XM;
                finish_row(pend, bit'($urandom_range(0, 1)), nx, $urandom_range(0, 127),
                           $urandom_range(0, 1), $urandom_range(0, 7), res);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
